tx_rr_arbiter: RTL
==================

// Module: tx_rr_arbiter
// PURPOSE
//  Round-robin burst arbiter that shares the phy_tx 2:1 lane mux between two
//  first-word-fall-through (FWFT) lane FIFOs. It pops words from the granted FIFO
//  only while the downstream FIFO is not almost-full. It drives a registered
//  data/valid stream into the downstream FIFO.
//  It sits between the per-lane FIFOs and the downstream FIFO in phy_tx.
// PARAMETERS
//  DATA_W   8   word width of lane and output data
//  BURST    4   max consecutive pops per grant while the other lane is waiting (>=1)
//  CNT_W    3   burst counter width; must satisfy 2**CNT_W > BURST
// PORTS
//  clk           in   1       single clock; all state updates on posedge
//  reset_L       in   1       synchronous, active-low reset
//  fifo_empty0   in   1       lane0 FIFO empty
//  fifo_data0    in   DATA_W  lane0 FIFO head word (FWFT, valid when !fifo_empty0)
//  fifo_empty1   in   1       lane1 FIFO empty
//  fifo_data1    in   DATA_W  lane1 FIFO head word (FWFT)
//  almost_full   in   1       downstream FIFO almost full (backpressure)
//  pop0          out  1       combinational read strobe to lane0 FIFO
//  pop1          out  1       combinational read strobe to lane1 FIFO
//  data_out      out  DATA_W  registered selected word
//  valid_out     out  1       registered; high exactly one cycle after each pop
//  grant         out  1       registered current owner (0 = lane0, 1 = lane1)
// BEHAVIOUR
//  Reset (reset_L=0 at posedge):
//   - state=IDLE, data_out=0, valid_out=0, grant=0, burst_cnt=0, last=1.
//   - pop0/pop1 are gated low whenever reset_L=0, so no word is lost.
//  States: IDLE, GNT0, GNT1. Encoding is two bits.
//  Pop rule (no pop ever occurs in IDLE):
//   - pop0 = reset_L & (state==GNT0) & !fifo_empty0 & !almost_full
//   - pop1 = reset_L & (state==GNT1) & !fifo_empty1 & !almost_full
//  Datapath, every cycle:
//   - valid_out <= pop0|pop1.
//   - data_out <= fifo_dataX on popX; otherwise data_out holds its value.
//   - Latency from pop to valid_out is 1 cycle.
//  IDLE (this is a one-cycle arbitration bubble):
//   - almost_full, or both lanes empty: stay in IDLE.
//   - Exactly one lane non-empty: go to GNTx for that lane.
//   - Both lanes non-empty: go to GNT(!last).
//   - On entry to GNTx: grant<=x, last<=x, burst_cnt<=0.
//  GNTx:
//   - almost_full=1: hold state and burst_cnt (stall); no pop.
//   - fifo_emptyx=1 and the other lane is non-empty: go straight to GNT(other);
//     cnt<=0, no bubble. If the other lane is also empty: go to IDLE.
//   - popx with burst_cnt==BURST-1 and the other lane non-empty: go to
//     GNT(other), cnt<=0. The switch has no bubble; the next pop comes from the
//     other lane in the following cycle.
//   - popx with burst_cnt==BURST-1 and the other lane empty: stay in GNTx, cnt<=0.
//   - popx otherwise: cnt<=cnt+1. No wrap past BURST-1.
//  Simultaneous events:
//   - almost_full has priority over every transition except reset.
//   - Empty-check uses the current-cycle flags.
//  Reset mid-burst: any in-flight grant is abandoned. The next grant after reset
//  goes to lane0 when both lanes request (last=1).
//  A lane is never starved: the waiting lane is granted after <= BURST pops.
// STRUCTURE
//  - Shared include phy_tx_defs.vh: state localparams ST_IDLE/ST_GNT0/ST_GNT1,
//    LANE0/LANE1, default DATA_W.
//  - One sub-module, tx_burst_cnt: CNT_W counter with clear, enable, and hold
//    inputs, plus a terminal-count (==BURST-1) output.
//  - FSM, pop gating, and output registers stay in tx_rr_arbiter.
// TESTING
//  1 Reset: reset_L=0 for 2 cycles, both FIFOs non-empty -> pop0=pop1=0,
//    data_out=0x00, valid_out=0, grant=0.
//  2 Single lane: lane0 holds 0xA1,0xA2,0xA3, lane1 empty -> one IDLE cycle, then
//    pop0 for 3 cycles -> valid_out for 3 cycles with A1,A2,A3 (1-cycle lag),
//    then IDLE.
//  3 Fairness, BURST=4: both lanes hold 8 words (0x0n, 0x1n) -> output
//    00..03, 10..13, 04..07, 14..17; valid_out continuous after the first bubble.
//  4 Backpressure: almost_full=1 for 3 cycles after the 2nd pop of a burst ->
//    pops stop the same cycle and valid_out drops the next cycle. The burst then
//    resumes with exactly 2 more pops before switching.
//  5 Early empty: lane0 empties after 2 pops while lane1 has 0x55 -> GNT1 the
//    next cycle, pop1 -> data_out=0x55, grant=1.
//  6 Reset mid-burst: reset_L=0 for 1 cycle after 2 pops, both lanes non-empty
//    -> no pop in the reset cycle, then IDLE, then grant=0 (lane0 first).

Source files
------------

// File: rtl/tx_rr_arbiter_pkg.sv
// Shared definitions for the phy_tx lane arbiter: FSM state codes, lane ids,
// default data width and a helper that maps a lane to its grant state.
package tx_rr_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam int DATA_W_DEF = 8;

  function automatic logic [1:0] gnt_state(input logic lane);
    return (lane == LANE1) ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/tx_rr_arbiter_burst_cnt.sv
// Burst length counter: counts pops within one grant and flags the last
// allowed pop (count == BURST-1). Hold wins over clear, clear over enable.
module tx_burst_cnt #(
  parameter int BURST = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic reset_L,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_hold,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(BURST - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc = (r_cnt == TC_VAL);

  // Counter never runs past the terminal value; an enable at tc wraps to zero.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_cnt <= '0;
    end else if (i_hold) begin
      r_cnt <= r_cnt;
    end else if (i_clr || (i_en && o_tc)) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/tx_rr_arbiter.sv
// Round-robin burst arbiter feeding the phy_tx downstream FIFO from two FWFT
// lane FIFOs, with almost-full backpressure and a registered output stream.
module tx_rr_arbiter
  import tx_rr_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BURST  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              fifo_empty0,
  input  logic [DATA_W-1:0] fifo_data0,
  input  logic              fifo_empty1,
  input  logic [DATA_W-1:0] fifo_data1,
  input  logic              almost_full,
  output logic              pop0,
  output logic              pop1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              grant
);

  logic [1:0]        r_state;
  logic              r_grant;
  logic              r_last;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  logic [1:0] w_nxt_state;
  logic       w_nxt_grant;
  logic       w_nxt_last;
  logic       w_cnt_clr;
  logic       w_cnt_en;
  logic       w_cnt_hold;
  logic       w_cnt_tc;
  logic       w_req0;
  logic       w_req1;
  logic       w_cur;
  logic       w_req_cur;
  logic       w_req_oth;
  logic       w_idle_lane;
  logic       w_pop0;
  logic       w_pop1;

  assign w_req0    = !fifo_empty0;
  assign w_req1    = !fifo_empty1;
  assign w_cur     = (r_state == ST_GNT1);
  assign w_req_cur = w_cur ? w_req1 : w_req0;
  assign w_req_oth = w_cur ? w_req0 : w_req1;
  // With both lanes requesting, the lane not served last wins.
  assign w_idle_lane = (w_req0 && w_req1) ? !r_last : w_req1;

  assign w_pop0 = reset_L & (r_state == ST_GNT0) & w_req0 & !almost_full;
  assign w_pop1 = reset_L & (r_state == ST_GNT1) & w_req1 & !almost_full;

  tx_burst_cnt #(
    .BURST (BURST),
    .CNT_W (CNT_W)
  ) u_burst_cnt (
    .clk     (clk),
    .reset_L (reset_L),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_hold  (w_cnt_hold),
    .o_tc    (w_cnt_tc)
  );

  // Next-state, grant bookkeeping and burst counter control.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = r_grant;
    w_nxt_last  = r_last;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_hold  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (almost_full || (!w_req0 && !w_req1)) begin
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_state = gnt_state(w_idle_lane);
          w_nxt_grant = w_idle_lane;
          w_nxt_last  = w_idle_lane;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (almost_full) begin
          w_cnt_hold = 1'b1;
        end else if (!w_req_cur || w_cnt_tc) begin
          w_cnt_clr = 1'b1;
          if (w_req_oth) begin
            w_nxt_state = gnt_state(!w_cur);
            w_nxt_grant = !w_cur;
            w_nxt_last  = !w_cur;
          end else if (!w_req_cur) begin
            w_nxt_state = ST_IDLE;
          end else begin
            w_nxt_state = r_state;
          end
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  // State, grant history and the registered output stream.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state <= ST_IDLE;
      r_grant <= LANE0;
      r_last  <= LANE1;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_grant <= w_nxt_grant;
      r_last  <= w_nxt_last;
      r_valid <= w_pop0 | w_pop1;
      if (w_pop0) begin
        r_data <= fifo_data0;
      end else if (w_pop1) begin
        r_data <= fifo_data1;
      end else begin
        r_data <= r_data;
      end
    end
  end

  assign pop0      = w_pop0;
  assign pop1      = w_pop1;
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign grant     = r_grant;

endmodule
